// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Holds the sequencer state enum, divider constants and op-kind codes.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } md_state_e;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // Op kinds as seen by the decode stage
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MF    = 3'd7;

    // Magnitude of a possibly signed operand; 0x80000000 wraps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v,
                                          input logic        sgn);
        return (sgn && v[31]) ? 32'(-v) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// 32-bit restoring divider datapath, one shift-subtract step per enable.
// Ports: clk, clear (sync zero), start (load operands), en (step),
// dividend/divisor magnitudes in, quot/rem out.
module div_iter (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem
);
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [32:0] trial;

    // Partial remainder shifted left by one, pulling in the next
    // dividend bit from the top of the quotient register.
    assign shifted = {rem_q, quot_q[31]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (clear) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
        end else if (start) begin
            rem_q  <= '0;
            quot_q <= dividend;
            dvs_q  <= divisor;
        end else if (en) begin
            if (!trial[32]) begin
                rem_q  <= trial[31:0];
                quot_q <= {quot_q[30:0], 1'b1};
            end else begin
                rem_q  <= shifted[31:0];
                quot_q <= {quot_q[30:0], 1'b0};
            end
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 32-step divide,
// mthi/mtlo writes and EX stall on HI/LO hazards.
// Ports: clk, reset (sync, active-high), EX op decode and operands, flush;
// outputs stall, busy, hi, lo. Param MUL_LAT = multiply latency (>=1).
// Build option: MULDIV_CANCEL_EN makes a flush abort an in-flight op.
module muldiv_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        is_mult,
    input  logic        is_multu,
    input  logic        is_div,
    input  logic        is_divu,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic        rd_hi,
    input  logic        rd_lo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import muldiv_pkg::*;

    localparam int MW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int CW = (MW > 5) ? MW : 5;

    md_state_e   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]  op;
    logic        touch;
    logic        accept;
    logic        cancel;
    logic        mul_commit;
    logic        div_commit;
    logic        div_start;
    logic        div_step;
    logic        mul_sgn;
    logic        div_sgn;
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] prod;
    logic [63:0] prod_q;
    logic        q_neg;
    logic        r_neg;
    logic        div0;
    logic [31:0] dvd_raw;
    logic [31:0] d_quot;
    logic [31:0] d_rem;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    always_comb begin
        op = OP_NONE;
        if (ex_valid) begin
            unique case (1'b1)
                is_mult:         op = OP_MULT;
                is_multu:        op = OP_MULTU;
                is_div:          op = OP_DIV;
                is_divu:         op = OP_DIVU;
                hi_wen:          op = OP_MTHI;
                lo_wen:          op = OP_MTLO;
                (rd_hi | rd_lo): op = OP_MF;
                default:         op = OP_NONE;
            endcase
        end
    end

    assign touch = (op != OP_NONE);

`ifdef MULDIV_CANCEL_EN
    assign cancel = flush & (state != ST_IDLE);
`else
    assign cancel = 1'b0;
`endif

    // Sign-extend only for signed multiply; low 64 bits of the product
    // of the extended operands is then the correct signed product.
    assign mul_sgn = (op == OP_MULT);
    assign div_sgn = (op == OP_DIV);
    assign a64     = {{32{mul_sgn & rs_data[31]}}, rs_data};
    assign b64     = {{32{mul_sgn & rt_data[31]}}, rt_data};
    assign prod    = a64 * b64;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        busy       = (state != ST_IDLE);
        stall      = touch & busy;
        accept     = touch & ~busy & ~flush;
        mul_commit = 1'b0;
        div_commit = 1'b0;
        div_start  = 1'b0;
        div_step   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept && (op == OP_MULT || op == OP_MULTU)) begin
                    state_nxt = ST_MUL;
                    cnt_nxt   = CW'(MUL_LAT - 1);
                end else if (accept && (op == OP_DIV || op == OP_DIVU)) begin
                    state_nxt = ST_DIV;
                    cnt_nxt   = '0;
                    div_start = 1'b1;
                end
            end
            ST_MUL: begin
                if (cnt == '0) begin
                    state_nxt  = ST_IDLE;
                    mul_commit = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (cnt == CW'(DIV_ITERS - 1)) begin
                    state_nxt = ST_FIX;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_FIX: begin
                div_commit = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (cancel) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = '0;
            mul_commit = 1'b0;
            div_commit = 1'b0;
            div_step   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q  <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            div0    <= 1'b0;
            dvd_raw <= '0;
        end else begin
            if (accept && (op == OP_MULT || op == OP_MULTU))
                prod_q <= prod;
            if (div_start) begin
                q_neg   <= div_sgn & (rs_data[31] ^ rt_data[31]);
                r_neg   <= div_sgn & rs_data[31];
                div0    <= (rt_data == '0);
                dvd_raw <= rs_data;
            end
        end
    end

    div_iter u_div (
        .clk      (clk),
        .clear    (reset | cancel),
        .start    (div_start),
        .en       (div_step),
        .dividend (mag32(rs_data, div_sgn)),
        .divisor  (mag32(rt_data, div_sgn)),
        .quot     (d_quot),
        .rem      (d_rem)
    );

    assign q_fix = q_neg ? 32'(-d_quot) : d_quot;
    assign r_fix = r_neg ? 32'(-d_rem)  : d_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_commit) begin
            hi <= prod_q[63:32];
            lo <= prod_q[31:0];
        end else if (div_commit) begin
            hi <= div0 ? dvd_raw   : r_fix;
            lo <= div0 ? DIV0_QUOT : q_fix;
        end else if (accept && op == OP_MTHI) begin
            hi <= rs_data;
        end else if (accept && op == OP_MTLO) begin
            lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected {hi,lo}
// pushed at issue and popped when the unit drops busy.
module tb_muldiv_ctrl;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        is_mult, is_multu, is_div, is_divu;
    logic        hi_wen, lo_wen, rd_hi, rd_lo;
    logic [31:0] rs_data, rt_data;
    logic        flush;
    logic        stall, busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .ex_valid (ex_valid),
        .is_mult  (is_mult),
        .is_multu (is_multu),
        .is_div   (is_div),
        .is_divu  (is_divu),
        .hi_wen   (hi_wen),
        .lo_wen   (lo_wen),
        .rd_hi    (rd_hi),
        .rd_lo    (rd_lo),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // k: 0 mult, 1 multu, 2 div, 3 divu; result is {hi,lo}
    function automatic logic [63:0] model(input int k,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0] up;
        int sa, sd;
        sa = a;
        sd = b;
        if (k == 0) begin
            sp = $signed(a) * $signed(b);
            return sp;
        end
        if (k == 1) begin
            up = a * b;
            return up;
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (k == 3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
        return {32'(sa % sd), 32'(sa / sd)};
    endfunction

    task automatic idle_in();
        ex_valid = 0;
        is_mult  = 0;
        is_multu = 0;
        is_div   = 0;
        is_divu  = 0;
        hi_wen   = 0;
        lo_wen   = 0;
        rd_hi    = 0;
        rd_lo    = 0;
        flush    = 0;
    endtask

    task automatic set_op(input int k, input logic [31:0] a,
                          input logic [31:0] b);
        ex_valid = 1;
        is_mult  = (k == 0);
        is_multu = (k == 1);
        is_div   = (k == 2);
        is_divu  = (k == 3);
        rs_data  = a;
        rt_data  = b;
    endtask

    task automatic issue(input int k, input logic [31:0] a,
                         input logic [31:0] b);
        set_op(k, a, b);
        sb.push_back(model(k, a, b));
        @(posedge clk);
        #1 idle_in();
    endtask

    task automatic sb_check(input string tag);
        if (sb.size() == 0) chk({tag, "_sb"}, 0, 1);
        else chk(tag, {hi, lo}, sb.pop_front());
    endtask

    // Count busy cycles (bounded), then compare against the scoreboard.
    task automatic finish_op(input string tag, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, n, lat);
        sb_check(tag);
    endtask

    task automatic mt(input bit to_hi, input logic [31:0] v);
        ex_valid = 1;
        hi_wen   = to_hi;
        lo_wen   = !to_hi;
        rs_data  = v;
        @(posedge clk);
        #1 idle_in();
    endtask

    initial begin
        int n;
        int rk;
        logic [31:0] ra, rb;
        logic [63:0] exp_hl;

        idle_in();
        rs_data = '0;
        rt_data = '0;
        reset   = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);

        // mthi
        @(posedge clk);
        #1;
        ex_valid = 1;
        hi_wen   = 1;
        rs_data  = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_stall", stall, 0);
        @(posedge clk);
        #1 idle_in();
        @(negedge clk);
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo", lo, 0);
        chk("mthi_busy", busy, 0);

        // multiply signed / unsigned
        @(posedge clk);
        #1 issue(0, 32'hFFFF_FFFF, 32'h2);
        finish_op("mult", MUL_LAT);
        chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk);
        #1 issue(1, 32'hFFFF_FFFF, 32'h2);
        finish_op("multu", MUL_LAT);
        chk("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        // div -7/2 with dependent mflo right behind it
        @(posedge clk);
        #1 set_op(2, 32'hFFFF_FFF9, 32'h2);
        sb.push_back(model(2, 32'hFFFF_FFF9, 32'h2));
        @(posedge clk);
        #1;
        is_div = 0;
        rd_lo  = 1;
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("mflo_stall", n, 33);
        chk("mflo_val", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        chk("mflo_busy", busy, 0);
        sb_check("div_m7_2");
        @(posedge clk);
        #1 idle_in();

        // divide boundaries
        issue(3, 32'd100, 32'h0);
        finish_op("divu_by0", 33);
        @(posedge clk);
        #1 issue(2, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 33);
        @(posedge clk);
        #1 issue(2, 32'hFFFF_FFF9, 32'h0);
        finish_op("div_neg_by0", 33);
        @(posedge clk);
        #1 issue(2, 32'h8000_0000, 32'h3);
        finish_op("div_min", 33);

        // random mix
        for (int i = 0; i < 8; i++) begin
            rk = $urandom_range(0, 3);
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
            else rb = $urandom;
            @(posedge clk);
            #1 issue(rk, ra, rb);
            finish_op($sformatf("rnd%0d", i), (rk < 2) ? MUL_LAT : 33);
        end

        // flush in the middle of a divide
        @(posedge clk);
        #1 mt(1, 32'hA5A5_A5A5);
        mt(0, 32'hA5A5_A5A5);
        set_op(2, 32'd1000, 32'd7);
        @(posedge clk);
        #1 idle_in();
        repeat (9) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
`ifdef MULDIV_CANCEL_EN
        exp_hl = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        chk("cancel_busy", busy, 0);
        chk("cancel_hilo", {hi, lo}, exp_hl);
`else
        exp_hl = model(2, 32'd1000, 32'd7);
        sb.push_back(exp_hl);
        finish_op("div_flush", 23);
`endif

        // flush coincident with mult issue
        @(posedge clk);
        #1 set_op(0, 32'h3, 32'h4);
        flush = 1;
        @(negedge clk);
        chk("flush_iss_stall", stall, 0);
        @(posedge clk);
        #1 idle_in();
        @(negedge clk);
        chk("flush_iss_busy", busy, 0);
        chk("flush_iss_hilo", {hi, lo}, exp_hl);

        // reset mid-operation
        @(posedge clk);
        #1 set_op(2, 32'd50, 32'd3);
        @(posedge clk);
        #1 idle_in();
        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_hilo", {hi, lo}, 0);
        @(posedge clk);
        #1 issue(1, 32'd6, 32'd7);
        finish_op("post_rst_mul", MUL_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
